// File: rtl/adder_issue_seq.sv
// Queued adder issue engine: opcodes enter a small FIFO and, during a run,
// one opcode per cycle reads two operands, adds them and writes a word.
module adder_issue_seq #(
    parameter int NUM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [39:0] op_data,
    input  logic        load_en,
    input  logic [5:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        run_start,
    input  logic [7:0]  run_count,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ops_done,
    output logic        carry
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_t            state;
    logic [7:0]        target;
    logic [39:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic [31:0]       words [NUM_WORDS];

    logic              push;
    logic              pop;
    logic [39:0]       head;
    logic [31:0]       val_a;
    logic [31:0]       val_b;
    logic [32:0]       sum;
    logic [7:0]        ops_inc;
    logic              wr_en;
    logic [5:0]        wr_idx;
    logic [31:0]       wr_val;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Operand field: bit16 selects sign-extended immediate or a word index.
    function automatic logic [31:0] operand(input logic [16:0] f, input logic [31:0] word_val);
        return f[16] ? {{16{f[15]}}, f[15:0]} : word_val;
    endfunction

    assign op_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push     = op_valid && op_ready;
    assign pop      = (state == RUN) && (fifo_count != '0);
    assign head     = fifo_mem[rd_ptr];
    assign val_a    = operand(head[39:23], words[head[28:23]]);
    assign val_b    = operand(head[22:6], words[head[11:6]]);
    assign sum      = {1'b0, val_a} + {1'b0, val_b};
    assign ops_inc  = ops_done + 8'd1;
    assign rd_data  = words[rd_addr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= op_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Execution and loads never collide: loads are only honoured outside RUN.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = load_addr;
        wr_val = load_data;
        if (pop) begin
            wr_en  = 1'b1;
            wr_idx = head[5:0];
            wr_val = sum[31:0];
        end else if (load_en && state != RUN) begin
            wr_en  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                words[i] <= '0;
            end
        end else if (wr_en) begin
            words[wr_idx] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            target   <= '0;
            ops_done <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run_start) begin
                        ops_done <= '0;
                        carry    <= 1'b0;
                        target   <= run_count;
                        if (run_count != 8'd0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        ops_done <= ops_inc;
                        carry    <= carry | sum[32];
                        if (ops_inc == target) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_issue_seq.sv
// Directed test of adder_issue_seq: loads, queued adds, stalls, carry and reset.
module tb_adder_issue_seq;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic        op_ready;
    logic [39:0] op_data;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        run_start;
    logic [7:0]  run_count;
    logic        busy;
    logic        done;
    logic [7:0]  ops_done;
    logic        carry;

    int checks   = 0;
    int failures = 0;
    int busy_cycles;

    adder_issue_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_data   (op_data),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .run_start (run_start),
        .run_count (run_count),
        .busy      (busy),
        .done      (done),
        .ops_done  (ops_done),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [16:0] addrOp(input logic [5:0] idx);
        return {1'b0, 10'd0, idx};
    endfunction

    function automatic logic [16:0] immOp(input logic [15:0] v);
        return {1'b1, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [5:0] idx, input logic [31:0] expected);
        rd_addr = idx;
        #1;
        checkOutput(tag, rd_data, expected);
    endtask

    task automatic loadWord(input logic [5:0] idx, input logic [31:0] val);
        load_en   = 1'b1;
        load_addr = idx;
        load_data = val;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic enqueueOp(input logic [16:0] a, input logic [16:0] b, input logic [5:0] dest);
        op_valid = 1'b1;
        op_data  = {a, b, dest};
        tick();
        op_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] count);
        run_start = 1'b1;
        run_count = count;
        tick();
        run_start = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int busy_seen);
        int n;
        n = 0;
        busy_seen = 0;
        while (!done && n < budget) begin
            if (busy) busy_seen++;
            tick();
            n++;
        end
        checkOutput("done_reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op_data   = '0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        rd_addr   = '0;
        run_start = 1'b0;
        run_count = '0;
        #12;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_ops_done", {24'd0, ops_done}, 32'd0);
        checkOutput("rst_carry", {31'd0, carry}, 32'd0);
        checkOutput("rst_op_ready", {31'd0, op_ready}, 32'd1);
        checkWord("rst_w0", 6'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single add from two loaded words.
        loadWord(6'd1, 32'd35);
        loadWord(6'd2, 32'd67);
        enqueueOp(addrOp(6'd1), addrOp(6'd2), 6'd6);
        applyStimulus(8'd1);
        checkOutput("r1_busy", {31'd0, busy}, 32'd1);
        checkOutput("r1_ops_before", {24'd0, ops_done}, 32'd0);
        tick();
        checkOutput("r1_done", {31'd0, done}, 32'd1);
        checkOutput("r1_busy_off", {31'd0, busy}, 32'd0);
        checkOutput("r1_ops_done", {24'd0, ops_done}, 32'd1);
        checkOutput("r1_carry", {31'd0, carry}, 32'd0);
        checkWord("r1_w6", 6'd6, 32'd102);
        tick();
        checkOutput("r1_done_pulse", {31'd0, done}, 32'd0);
        checkOutput("r1_ops_hold", {24'd0, ops_done}, 32'd1);

        // Three pre-queued dependent adds, including a negative immediate.
        enqueueOp(immOp(16'd15), addrOp(6'd2), 6'd8);
        enqueueOp(addrOp(6'd6), addrOp(6'd8), 6'd50);
        enqueueOp(immOp(16'hFFF1), addrOp(6'd8), 6'd10);
        applyStimulus(8'd3);
        waitDone(10, busy_cycles);
        checkOutput("r3_busy_cycles", busy_cycles, 32'd3);
        checkOutput("r3_ops_done", {24'd0, ops_done}, 32'd3);
        checkWord("r3_w8", 6'd8, 32'd82);
        checkWord("r3_w50", 6'd50, 32'd184);
        checkWord("r3_w10", 6'd10, 32'd67);
        tick();

        // Fill the queue; the fifth opcode waits for the first pop.
        op_valid = 1'b1;
        op_data  = {immOp(16'd1), immOp(16'd2), 6'd20};
        checkOutput("q_ready0", {31'd0, op_ready}, 32'd1);
        tick();
        op_data  = {immOp(16'd10), immOp(16'd20), 6'd21};
        checkOutput("q_ready1", {31'd0, op_ready}, 32'd1);
        tick();
        op_data  = {addrOp(6'd20), addrOp(6'd21), 6'd22};
        checkOutput("q_ready2", {31'd0, op_ready}, 32'd1);
        tick();
        op_data  = {immOp(16'hFFFF), immOp(16'd0), 6'd23};
        checkOutput("q_ready3", {31'd0, op_ready}, 32'd1);
        tick();
        op_data  = {addrOp(6'd22), immOp(16'd100), 6'd24};
        checkOutput("q_full", {31'd0, op_ready}, 32'd0);
        tick();
        checkOutput("q_full_held", {31'd0, op_ready}, 32'd0);
        applyStimulus(8'd5);
        checkOutput("q_full_run", {31'd0, op_ready}, 32'd0);
        tick();
        checkOutput("q_ready_after_pop", {31'd0, op_ready}, 32'd1);
        tick();
        op_valid = 1'b0;
        waitDone(10, busy_cycles);
        checkOutput("q_ops_done", {24'd0, ops_done}, 32'd5);
        checkOutput("q_carry", {31'd0, carry}, 32'd0);
        checkWord("q_w22", 6'd22, 32'd33);
        checkWord("q_w23", 6'd23, 32'hFFFFFFFF);
        checkWord("q_w24", 6'd24, 32'd133);
        tick();

        // Carry out of bit 31, then cleared by the next run.
        loadWord(6'd3, 32'hFFFFFFFF);
        enqueueOp(addrOp(6'd3), immOp(16'd1), 6'd3);
        applyStimulus(8'd1);
        waitDone(10, busy_cycles);
        checkOutput("c_carry", {31'd0, carry}, 32'd1);
        checkWord("c_w3", 6'd3, 32'd0);
        tick();
        checkOutput("c_carry_hold", {31'd0, carry}, 32'd1);
        enqueueOp(immOp(16'd5), immOp(16'd6), 6'd30);
        applyStimulus(8'd1);
        waitDone(10, busy_cycles);
        checkOutput("c_carry_clear", {31'd0, carry}, 32'd0);
        checkWord("c_w30", 6'd30, 32'd11);
        tick();

        // Stall with an empty queue; run_start and load_en ignored in RUN.
        enqueueOp(immOp(16'd7), immOp(16'd8), 6'd40);
        applyStimulus(8'd3);
        tick();
        tick();
        tick();
        checkOutput("s_busy", {31'd0, busy}, 32'd1);
        checkOutput("s_ops_done", {24'd0, ops_done}, 32'd1);
        checkOutput("s_not_done", {31'd0, done}, 32'd0);
        applyStimulus(8'd1);
        checkOutput("s_restart_ignored", {24'd0, ops_done}, 32'd1);
        checkOutput("s_busy_still", {31'd0, busy}, 32'd1);
        loadWord(6'd40, 32'd999);
        checkWord("s_load_ignored", 6'd40, 32'd15);
        enqueueOp(addrOp(6'd40), immOp(16'd1), 6'd41);
        enqueueOp(addrOp(6'd41), immOp(16'd1), 6'd42);
        waitDone(10, busy_cycles);
        checkOutput("s_ops_final", {24'd0, ops_done}, 32'd3);
        checkWord("s_w41", 6'd41, 32'd16);
        checkWord("s_w42", 6'd42, 32'd17);
        tick();

        // Reset in the middle of a run with two opcodes still queued.
        enqueueOp(immOp(16'd9), immOp(16'd9), 6'd60);
        enqueueOp(immOp(16'd4), immOp(16'd4), 6'd61);
        enqueueOp(immOp(16'd2), immOp(16'd2), 6'd62);
        applyStimulus(8'd3);
        tick();
        checkWord("x_w60_pre", 6'd60, 32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("x_busy", {31'd0, busy}, 32'd0);
        checkOutput("x_ops_done", {24'd0, ops_done}, 32'd0);
        checkOutput("x_op_ready", {31'd0, op_ready}, 32'd1);
        checkWord("x_w60", 6'd60, 32'd0);
        checkWord("x_w1", 6'd1, 32'd0);
        tick();
        checkWord("x_w61", 6'd61, 32'd0);
        rst_n = 1'b1;
        tick();
        applyStimulus(8'd0);
        checkOutput("z_done", {31'd0, done}, 32'd1);
        checkOutput("z_ops_done", {24'd0, ops_done}, 32'd0);
        checkOutput("z_busy", {31'd0, busy}, 32'd0);
        tick();
        checkOutput("z_done_pulse", {31'd0, done}, 32'd0);
        applyStimulus(8'd1);
        tick();
        tick();
        checkOutput("e_queue_empty", {24'd0, ops_done}, 32'd0);
        checkOutput("e_busy", {31'd0, busy}, 32'd1);
        enqueueOp(immOp(16'd2), immOp(16'd3), 6'd5);
        waitDone(10, busy_cycles);
        checkOutput("e_ops_done", {24'd0, ops_done}, 32'd1);
        checkWord("e_w5", 6'd5, 32'd5);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_issue_seq.md
ADDER_ISSUE_SEQ -- requirements
Module: adder_issue_seq

Interface
REQ-001 Parameter NUM_WORDS, 64, number of 32-bit words in the execution word file (index width 6).
REQ-002 Parameter FIFO_DEPTH, 4, depth of the opcode queue.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 op_valid  input  1  opcode source presents op_data.
REQ-006 op_ready  output  1  queue can accept an opcode this cycle.
REQ-007 op_data  input  40  adder opcode: [39:23] operand A, [22:6] operand B, [5:0] dest word index.
REQ-008 load_en  input  1  write load_data into word load_addr.
REQ-009 load_addr  input  6  word index for load.
REQ-010 load_data  input  32  load value.
REQ-011 rd_addr  input  6  word index for readback.
REQ-012 rd_data  output  32  current value of word rd_addr (combinational read).
REQ-013 run_start  input  1  request to execute run_count opcodes.
REQ-014 run_count  input  8  number of opcodes to execute, sampled on accepted run_start.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 ops_done  output  8  opcodes executed in the current/last run.
REQ-018 carry  output  1  sticky: some add in the current/last run carried out of bit 31.

Function
REQ-019 The operand field is 17 bits: bit16=1 means immediate (bits[15:0] sign-extended to 32 bits); bit16=0 means address (bits[5:0] = word index, bits[15:6] ignored).
REQ-020 An opcode is enqueued when op_valid && op_ready; op_ready = queue not full, independent of a same-cycle pop.
REQ-021 The FSM has states IDLE, RUN, DONE; reset state is IDLE.
REQ-022 IDLE: run_start with run_count>0 -> RUN, latching run_count and clearing ops_done and carry; run_start with run_count==0 -> DONE with ops_done=0.
REQ-023 RUN: each cycle the queue is non-empty, the head is popped and executed in that cycle: word[dest] <= (A + B) mod 2^32 at the clock edge; ops_done increments; carry |= bit 32 of the sum.
REQ-024 RUN with an empty queue stalls: no write, no count change, no timeout.
REQ-025 When the executed opcode makes ops_done equal the latched run_count, the FSM goes to DONE on the same edge.
REQ-026 DONE asserts done for exactly one cycle, then returns to IDLE; ops_done and carry hold until the next accepted run_start.
REQ-027 run_start is ignored in RUN and DONE.
REQ-028 Operands read pre-edge values: an opcode whose dest equals a source uses the old value; latency from pop to visible rd_data is 1 cycle.
REQ-029 load_en is honoured only in IDLE and DONE; it is ignored in RUN.
REQ-030 Opcodes remaining in the queue after DONE stay queued for the next run; enqueuing is permitted in every state.
REQ-031 Word 0 has no special meaning and may be written.

Reset
REQ-032 On rst_n low, asynchronously: FSM=IDLE, queue emptied, all words=0, busy=0, done=0, ops_done=0, carry=0, op_ready=1.
REQ-033 Reset asserted mid-RUN discards the run and queued opcodes with no partial write on that edge; after release, behaviour is as from power-up.

Verification
REQ-034 Load w1=35, w2=67; enqueue {A=addr1, B=addr2, dest=6}; run_count=1 -> w6=102, ops_done=1, done pulses once, carry=0.
REQ-035 Enqueue {imm 15, addr2, dest 8}, {addr6, addr8, dest 50}, {imm -15, addr8, dest 10}; run_count=3 -> w8=82, w50=184, w10=67; busy for 3 cycles when ops are pre-queued.
REQ-036 Enqueue 5 opcodes back-to-back in IDLE -> op_ready drops after 4 accepts; 5th held until a pop in RUN.
REQ-037 Load w3=0xFFFFFFFF; {addr3, imm 1, dest 3}; run_count=1 -> w3=0, carry=1; next run with a non-carrying add clears carry.
REQ-038 run_count=3 with 1 opcode queued -> stall with busy=1, ops_done=1; feed 2 more -> done, ops_done=3; run_start mid-RUN has no effect.
REQ-039 Assert rst_n low during RUN with 2 queued -> all words 0, queue empty, IDLE; run_count=0 afterwards -> done pulse with ops_done=0.
